// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: frame geometry, receive FSM states
// and the frame word carried between the transmit sequencer and this demux.
package tdm_pkg;

    localparam int CHANNELS = 8;
    localparam int SLOT_W   = 3;
    localparam int BEAT_W   = 1;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    typedef logic [CHANNELS*BEAT_W-1:0] tdm_frame_t;

    // Slot index that closes a frame.
    function automatic logic [SLOT_W-1:0] last_slot();
        return SLOT_W'(CHANNELS - 1);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM link: free-running wrap on inc, with restart
// loads to slot 0 (resync lost) and slot 1 (sync beat already consumed).
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load0,
    input  logic              load1,
    output logic [SLOT_W-1:0] sel,
    output logic              at_last
);

    // Loads take priority over increment; the natural binary wrap handles 7 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= '0;
        end else if (load0) begin
            sel <= '0;
        end else if (load1) begin
            sel <= SLOT_W'(1);
        end else if (inc) begin
            sel <= sel + 1'b1;
        end
    end

    assign at_last = (sel == last_slot());

endmodule

// File: rtl/tdm_demux_8ch.sv
// Receive side of the 8-to-1 TDM link: steers serial beats into channel
// slots and publishes each complete frame in parallel.
module tdm_demux_8ch
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DATA_W   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          din,
    input  logic                       din_valid,
    input  logic                       frame_sync,
    output logic [CHANNELS*DATA_W-1:0] out,
    output logic                       frame_valid,
    output logic [2:0]                 sel,
    output logic                       locked,
    output logic                       sync_err
);

    // Interface: din_valid qualifies din and frame_sync in the same cycle;
    // there is no ready, so every valid beat is consumed on that edge.

    tdm_state_t state_q, state_d;

    logic [CHANNELS*DATA_W-1:0] stage_q;
    logic [CHANNELS*DATA_W-1:0] out_q, out_d;
    logic                       fv_q, fv_d;
    logic                       err_q, err_d;

    logic                       cnt_inc, cnt_load0, cnt_load1;
    logic [SLOT_W-1:0]          cnt_sel;
    logic                       cnt_last;

    logic                       wr_en;
    logic [SLOT_W-1:0]          wr_slot;

    tdm_slot_counter u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .inc     (cnt_inc),
        .load0   (cnt_load0),
        .load1   (cnt_load1),
        .sel     (cnt_sel),
        .at_last (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        cnt_inc   = 1'b0;
        cnt_load0 = 1'b0;
        cnt_load1 = 1'b0;
        wr_en     = 1'b0;
        wr_slot   = '0;
        out_d     = out_q;
        fv_d      = 1'b0;
        err_d     = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        wr_en     = 1'b1;
                        cnt_load1 = 1'b1;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (cnt_sel == '0) begin
                        if (frame_sync) begin
                            wr_en   = 1'b1;
                            cnt_inc = 1'b1;
                        end else begin
                            err_d     = 1'b1;
                            cnt_load0 = 1'b1;
                            state_d   = HUNT;
                        end
                    end else if (frame_sync) begin
                        // Early sync: abandon the partial frame and restart on this beat.
                        err_d     = 1'b1;
                        wr_en     = 1'b1;
                        cnt_load1 = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_slot = cnt_sel;
                        cnt_inc = 1'b1;
                        if (cnt_last) begin
                            out_d = stage_q;
                            out_d[(CHANNELS-1)*DATA_W +: DATA_W] = din;
                            fv_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_load0 = 1'b1;
                    state_d   = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            stage_q <= '0;
            out_q   <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            if (wr_en) begin
                stage_q[int'(wr_slot)*DATA_W +: DATA_W] <= din;
            end
        end
    end

    assign out         = out_q;
    assign frame_valid = fv_q;
    assign sel         = cnt_sel;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Self-checking bench for tdm_demux_8ch: directed frames plus random traffic
// against a queue-based frame assembly model.
module tb_tdm_demux_8ch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] out;
    logic       frame_valid;
    logic [2:0] sel;
    logic       locked;
    logic       sync_err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit         m_locked = 1'b0;
    bit         m_beats[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_out = '0;

    tdm_demux_8ch #(.CHANNELS(8), .DATA_W(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .out         (out),
        .frame_valid (frame_valid),
        .sel         (sel),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_beats.delete();
        exp_q.delete();
        m_out = '0;
    endtask

    // One clock: drive on the falling edge, advance model and compare after the rising edge.
    task automatic step(input bit v, input bit d, input bit s);
        bit         exp_fv;
        bit         exp_err;
        logic [7:0] f;
        @(negedge clk);
        din_valid  = v;
        din        = d;
        frame_sync = s;
        @(posedge clk);
        #1;
        exp_fv  = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_beats.delete();
                    m_beats.push_back(d);
                    m_locked = 1'b1;
                end
            end else if (m_beats.size() == 0) begin
                if (s) m_beats.push_back(d);
                else begin
                    exp_err  = 1'b1;
                    m_locked = 1'b0;
                end
            end else if (s) begin
                exp_err = 1'b1;
                m_beats.delete();
                m_beats.push_back(d);
            end else begin
                m_beats.push_back(d);
                if (m_beats.size() == 8) begin
                    for (int i = 0; i < 8; i++) f[i] = m_beats[i];
                    m_out  = f;
                    exp_fv = 1'b1;
                    exp_q.push_back(f);
                    m_beats.delete();
                end
            end
        end
        check("frame_valid", 32'(frame_valid), 32'(exp_fv));
        check("sync_err", 32'(sync_err), 32'(exp_err));
        check("locked", 32'(locked), 32'(m_locked));
        check("sel", 32'(sel), m_locked ? 32'(m_beats.size()) : 32'd0);
        check("out", 32'(out), 32'(m_out));
        if (frame_valid) begin
            if (exp_q.size() == 0) check("frame_unexpected", 32'd1, 32'd0);
            else check("frame_sb", 32'(out), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] v, input int gap_min, input int gap_max);
        for (int i = 0; i < 8; i++) begin
            if (gap_max > 0 && i > 0) idle($urandom_range(gap_max, gap_min));
            step(1'b1, v[i], i == 0);
        end
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_fv", 32'(frame_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(out), 32'd0);
        check("reset_fv", 32'(frame_valid), 32'd0);
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_err", 32'(sync_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // alternating 0,1 data -> 8'b10101010
        send_frame(8'hAA, 0, 0);
        idle(1);
        check("first_frame", 32'(out), 32'hAA);

        // pre-sync beats are ignored while hunting, then F0
        step(1'b1, 1'b1, 1'b0);  // missing sync -> back to HUNT
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("hunt_locked", 32'(locked), 32'd0);
        send_frame(8'hF0, 0, 0);
        check("f0_frame", 32'(out), 32'hF0);

        // back-to-back frames
        send_frame(8'hAA, 0, 0);
        send_frame(8'h55, 0, 0);
        check("b2b_frame", 32'(out), 32'h55);

        // idle gaps of 1..3 cycles between beats
        send_frame(8'h96, 1, 3);
        check("gap_frame", 32'(out), 32'h96);

        // early sync at slot 4 of a new frame
        send_frame(8'h55, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0);
        step(1'b1, 1'b0, 1'b1);
        check("early_err", 32'(sync_err), 32'd1);
        check("early_sel", 32'(sel), 32'd1);
        check("early_out_hold", 32'(out), 32'h55);
        for (int i = 1; i < 8; i++) step(1'b1, (8'h3C >> i) & 1'b1, 1'b0);
        check("early_restart", 32'(out), 32'h3C);

        // missing sync at slot 0
        step(1'b1, 1'b1, 1'b0);
        check("miss_err", 32'(sync_err), 32'd1);
        check("miss_locked", 32'(locked), 32'd0);
        check("miss_sel", 32'(sel), 32'd0);

        // reset mid-frame
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i == 0);
        async_reset_check();
        idle(2);
        send_frame(8'hC3, 0, 0);

        // random traffic, sync mostly well placed
        for (int c = 0; c < 400; c++) begin
            bit v, d, s;
            v = ($urandom_range(99, 0) < 75);
            d = 1'($urandom_range(1, 0));
            if (m_locked && m_beats.size() != 0) s = ($urandom_range(99, 0) < 4);
            else s = ($urandom_range(99, 0) < 90);
            step(v, d, s);
        end
        idle(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
